axi_wr_slave_ctrl: RTL and testbench
====================================

// Module: axi_wr_slave_ctrl
// PURPOSE
//  AXI4 write-channel slave: accepts AW bursts, sinks W beats into an internal word memory, returns a B response.
//  Sits directly downstream of the master BFM on the write channels, beside the read-side slave.
//  Backdoor read port lets the monitor/scoreboard check memory contents without AXI reads.
// PARAMETERS
//  ADDR_WIDTH  32    byte address width
//  DATA_WIDTH  32    W data width; 32/64/128 only
//  ID_WIDTH    4     AWID/BID width
//  MEM_DEPTH   1024  memory depth in DATA_WIDTH words; power of 2
// PORTS
//  clk          in   1             clock, all logic on posedge
//  rst          in   1             reset, asynchronous, active-low
//  awid         in   ID_WIDTH      write address ID
//  awaddr       in   ADDR_WIDTH    start byte address
//  awlen        in   8             beats-1
//  awsize       in   3             log2 bytes per beat
//  awburst      in   2             0 FIXED, 1 INCR, 2 WRAP
//  awvalid      in   1             AW valid
//  awready      out  1             AW ready
//  wdata        in   DATA_WIDTH    write data
//  wstrb        in   DATA_WIDTH/8  byte strobes
//  wlast        in   1             last beat marker
//  wvalid       in   1             W valid
//  wready       out  1             W ready
//  bid          out  ID_WIDTH      response ID (= captured awid)
//  bresp        out  2             0 OKAY, 2 SLVERR
//  bvalid       out  1             B valid
//  bready       in   1             B ready
//  dbg_addr     in   $clog2(MEM_DEPTH)  backdoor word index
//  dbg_rdata    out  DATA_WIDTH    mem[dbg_addr], registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst=0): awready=1, wready=0, bvalid=0, bid=0, bresp=0, dbg_rdata=0, FSM->IDLE; memory not cleared.
//  Reset mid-burst aborts the burst: no B issued, beats already written stay in memory.
//  FSM: IDLE(awready=1) -AW hs-> DATA(wready=1) -W hs with beat==awlen-> RESP(bvalid=1) -B hs-> IDLE.
//  Latency: AW hs in cycle N -> wready=1 in N+1. Final W hs in M -> bvalid=1 in M+1. B hs in K -> awready=1 in K+1.
//  One outstanding burst; no AW accepted in DATA/RESP. bid/bresp/bvalid held stable until bready.
//  Burst ends on beat count (awlen+1), never on wlast alone.
//  Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH; only bytes with wstrb=1 are written.
//  Next address: FIXED unchanged; INCR aligned(addr,size) + (1<<awsize), first beat may be unaligned;
//   WRAP: span=(awlen+1)<<awsize, low=addr & ~(span-1), wraps to low on reaching low+span.
//  INCR address arithmetic is ADDR_WIDTH bits, wraps silently at 2^ADDR_WIDTH.
//  Error flag is sticky for the burst, cleared on AW hs; bresp=SLVERR if set, else OKAY.
// CONFIGURATION
//  Macro AXI_WR_ERR_CHK_EN defined: error flag set by awsize > log2(DATA_WIDTH/8); WRAP with awlen not in {1,3,7,15};
//   awburst==3; word index >= MEM_DEPTH; wlast != (beat==awlen). Any beat of a flagged burst is not written
//   (burst still fully consumed).
//  Undefined: no checks, index wraps mod MEM_DEPTH, awburst==3 treated as INCR, bresp always OKAY.
// STRUCTURE
//  axi_common_pkg: burst_t enum (FIXED/INCR/WRAP), resp_t enum (OKAY/EXOKAY/SLVERR/DECERR), wr_state_t enum.
//  Sub-module axi_wr_addr_gen: combinational next-address from addr/size/len/burst; used once per beat.
//  Memory as a plain reg array with per-byte write enables.
// TESTING
//  INCR: awaddr=0x10, awlen=3, awsize=2, wdata 1..4, wstrb=F -> mem[4..7]=1..4, bresp=0, bid=awid.
//  WRAP: awaddr=0x18, awlen=3, awsize=2 -> words written at 6,7,4,5; bresp=0.
//  FIXED + strobes: awaddr=0x0, awlen=1, beats 0xAABBCCDD wstrb=F then 0x11223344 wstrb=3 -> mem[0]=0xAABB3344.
//  Backpressure: bready=0 for 5 cycles -> bvalid/bid/bresp stable, awready=0 throughout; awready=1 the cycle after B hs.
//  Error (AXI_WR_ERR_CHK_EN): awsize=3 with DATA_WIDTH=32, awlen=0 -> mem unchanged, bresp=2; early wlast on beat 1 of awlen=3 -> bresp=2.
//  Reset: rst=0 after beat 2 of awlen=7 -> all outputs at reset values, no B; new burst after release completes OKAY.

Source files
------------

// File: rtl/axi_common_pkg.sv
// Shared AXI encodings for the write-channel slave: burst types, response codes, FSM states.
package axi_common_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'd0,
    RespExokay = 2'd1,
    RespSlverr = 2'd2,
    RespDecerr = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StResp = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts; the reserved encoding acts as INCR.
module axi_wr_addr_gen
  import axi_common_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] low;

  always_comb begin
    step    = ADDR_WIDTH'(1) << size;
    aligned = addr & ~(step - ADDR_WIDTH'(1));
    incr    = aligned + step;
    span    = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    low     = addr & ~(span - ADDR_WIDTH'(1));
    next_addr = incr;
    if (burst == BurstFixed) begin
      next_addr = addr;
    end else if (burst == BurstWrap && incr == low + span) begin
      next_addr = low;
    end
  end

endmodule

// File: rtl/axi_wr_slave_ctrl.sv
// AXI4 write slave: one outstanding burst into a byte-enabled word memory with a backdoor read port.
// Define AXI_WR_ERR_CHK_EN to enable protocol/range checking with SLVERR responses.
module axi_wr_slave_ctrl
  import axi_common_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned ByteLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);

  wr_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs, w_hs, last_beat;
  logic                  aw_err, beat_err, mem_we;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [IdxW-1:0]       widx;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign awready   = (state_q == StIdle);
  assign wready    = (state_q == StData);
  assign bvalid    = (state_q == StResp);
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign last_beat = (beat_q == len_q);
  assign widx      = addr_q[ByteLsb +: IdxW];

`ifdef AXI_WR_ERR_CHK_EN
  assign aw_err = ({1'b0, awsize} > 4'(ByteLsb)) ||
                  (awburst == BurstWrap && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  (awburst == 2'd3);
  // Any address bit above the word-index field means the index is past MEM_DEPTH.
  assign beat_err = ((addr_q >> (ByteLsb + IdxW)) != '0) || (wlast != last_beat);
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
  assign aw_err   = 1'b0;
  assign beat_err = 1'b0;
`endif

  assign mem_we = w_hs & ~(err_q | beat_err);

  axi_wr_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr     (addr_q),
    .size     (size_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    unique case (state_q)
      StIdle: begin
        if (aw_hs) begin
          state_d = StData;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          beat_d  = 8'd0;
          err_d   = aw_err;
          bid_d   = awid;
        end
      end
      StData: begin
        if (w_hs) begin
          addr_d = next_addr;
          beat_d = beat_q + 8'd1;
          err_d  = err_q | beat_err;
          // Beat count alone closes the burst; wlast only feeds the error check.
          if (last_beat) begin
            state_d = StResp;
            bresp_d = (err_q | beat_err) ? RespSlverr : RespOkay;
          end
        end
      end
      StResp: begin
        if (bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
    end
  end

  // Memory is deliberately left out of reset so contents survive a mid-burst abort.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dbg_rdata <= '0;
    else      dbg_rdata <= mem[dbg_addr];
  end

endmodule

// File: tb/tb_axi_wr_slave_ctrl.sv
// Self-checking bench for axi_wr_slave_ctrl: directed cases plus random bursts against a byte-level model.
module tb_axi_wr_slave_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;

  axi_wr_slave_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH  (4),
    .MEM_DEPTH (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl   [1024];
  logic [3:0]  known [1024];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Address of beat i, computed directly from the burst rules rather than step by step.
  function automatic logic [31:0] ref_addr(input logic [31:0] start, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input int i);
    logic [31:0] bytes, aligned, span, low;
    bytes   = 32'd1 << size;
    aligned = start & ~(bytes - 32'd1);
    if (i == 0 || burst == 2'd0) return start;
    if (burst == 2'd2) begin
      span = (32'(len) + 32'd1) * bytes;
      low  = start & ~(span - 32'd1);
      return low + ((aligned - low + 32'(i) * bytes) % span);
    end
    return aligned + 32'(i) * bytes;
  endfunction

  task automatic check_word(input int idx);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = known[idx][b] ? 8'hFF : 8'h00;
    @(negedge clk);
    dbg_addr = 10'(idx);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("mem[%0d]", idx), 64'(dbg_rdata & mask), 64'(mdl[idx] & mask));
  endtask

  // One full burst. last_at: beat carrying wlast; err_from: first beat not written (-1 none);
  // rst_after: assert reset once that many beats are accepted (-1 never).
  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int last_at,
                       input int err_from, input logic [1:0] exp_resp, input int bp_cycles,
                       input int rst_after, input bit gaps);
    int cnt;
    logic [31:0] a;
    int w;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    cnt = 0;
    while (awready !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("aw_wait", 64'(cnt < 50), 64'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready_after_aw", 64'(wready), 64'd1);
    chk("awready_in_data", 64'(awready), 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == rst_after) begin
        rst = 1'b0;
        wvalid = 1'b0;
        #1;
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bid", 64'(bid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_dbg", 64'(dbg_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_bvalid", 64'(bvalid), 64'd0);
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      cnt = 0;
      while (wready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
      if (cnt != 0) chk("w_wait", 64'(wready), 64'd1);
      wdata = beat_data[i]; wstrb = beat_strb[i]; wlast = (i == last_at); wvalid = 1'b1;
      a = ref_addr(addr, len, size, bt, i);
      w = int'((a >> 2) & 32'h3FF);
      if (err_from < 0 || i < err_from) begin
        for (int b = 0; b < 4; b++) begin
          if (beat_strb[i][b]) begin
            mdl[w][8*b +: 8] = beat_data[i][8*b +: 8];
            known[w][b] = 1'b1;
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last", 64'(bvalid), 64'd1);
    chk("wready_in_resp", 64'(wready), 64'd0);
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(exp_resp));
    for (int k = 0; k < bp_cycles; k++) begin
      @(negedge clk);
      chk("bp_bvalid", 64'(bvalid), 64'd1);
      chk("bp_bid", 64'(bid), 64'(id));
      chk("bp_bresp", 64'(bresp), 64'(exp_resp));
      chk("bp_awready", 64'(awready), 64'd0);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    chk("awready_after_b", 64'(awready), 64'd1);
    chk("bvalid_after_b", 64'(bvalid), 64'd0);
  endtask

  initial begin
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  bt;
    logic [31:0] addr;
    for (int k = 0; k < 1024; k++) begin mdl[k] = '0; known[k] = '0; end

    #1 rst = 1'b0;
    #1;
    chk("reset_awready", 64'(awready), 64'd1);
    chk("reset_wready", 64'(wready), 64'd0);
    chk("reset_bvalid", 64'(bvalid), 64'd0);
    chk("reset_bid", 64'(bid), 64'd0);
    chk("reset_bresp", 64'(bresp), 64'd0);
    chk("reset_dbg", 64'(dbg_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // INCR 0x10, 4 beats of 1..4
    for (int i = 0; i < 4; i++) begin beat_data[i] = 32'(i + 1); beat_strb[i] = 4'hF; end
    burst(4'h5, 32'h10, 8'd3, 3'd2, 2'd1, 3, -1, 2'd0, 0, -1, 1'b0);
    for (int i = 4; i < 8; i++) check_word(i);
    @(negedge clk); dbg_addr = 10'd7; @(posedge clk); @(negedge clk);
    chk("incr_word7", 64'(dbg_rdata), 64'd4);

    // WRAP 0x18 lands on words 6,7,4,5
    for (int i = 0; i < 4; i++) begin beat_data[i] = 32'hA0 + 32'(i); beat_strb[i] = 4'hF; end
    burst(4'h9, 32'h18, 8'd3, 3'd2, 2'd2, 3, -1, 2'd0, 0, -1, 1'b0);
    @(negedge clk); dbg_addr = 10'd4; @(posedge clk); @(negedge clk);
    chk("wrap_word4", 64'(dbg_rdata), 64'hA2);
    @(negedge clk); dbg_addr = 10'd6; @(posedge clk); @(negedge clk);
    chk("wrap_word6", 64'(dbg_rdata), 64'hA0);

    // FIXED with partial strobes on the second beat
    beat_data[0] = 32'hAABBCCDD; beat_strb[0] = 4'hF;
    beat_data[1] = 32'h11223344; beat_strb[1] = 4'h3;
    burst(4'h3, 32'h0, 8'd1, 3'd2, 2'd0, 1, -1, 2'd0, 0, -1, 1'b0);
    @(negedge clk); dbg_addr = 10'd0; @(posedge clk); @(negedge clk);
    chk("fixed_strb", 64'(dbg_rdata), 64'hAABB3344);

    // B backpressure for 5 cycles
    beat_data[0] = 32'h5A5A0001; beat_strb[0] = 4'hF;
    burst(4'hC, 32'h40, 8'd0, 3'd2, 2'd1, 0, -1, 2'd0, 5, -1, 1'b0);
    check_word(16);

`ifdef AXI_WR_ERR_CHK_EN
    beat_data[0] = 32'hDEADBEEF; beat_strb[0] = 4'hF;
    burst(4'h1, 32'h10, 8'd0, 3'd3, 2'd1, 0, 0, 2'd2, 0, -1, 1'b0);
    check_word(4);
    for (int i = 0; i < 4; i++) begin beat_data[i] = 32'hE0 + 32'(i); beat_strb[i] = 4'hF; end
    burst(4'h2, 32'h80, 8'd3, 3'd2, 2'd1, 1, 1, 2'd2, 0, -1, 1'b0);
    for (int i = 32; i < 36; i++) check_word(i);
`endif

    // Reset after two beats of an 8-beat burst, then a clean burst
    for (int i = 0; i < 8; i++) begin beat_data[i] = 32'hC0DE0000 + 32'(i); beat_strb[i] = 4'hF; end
    burst(4'h7, 32'h100, 8'd7, 3'd2, 2'd1, 7, -1, 2'd0, 0, 2, 1'b0);
    check_word(64);
    check_word(65);
    burst(4'h8, 32'h200, 8'd1, 3'd2, 2'd1, 1, -1, 2'd0, 0, -1, 1'b0);
    check_word(128);

    // Random bursts
    for (int n = 0; n < 30; n++) begin
`ifdef AXI_WR_ERR_CHK_EN
      bt = 2'($urandom_range(0, 2));
`else
      bt = 2'($urandom_range(0, 3));
`endif
      size = 3'($urandom_range(0, 2));
      if (bt == 2'd2) begin
        case ($urandom_range(0, 3))
          0: len = 8'd1;
          1: len = 8'd3;
          2: len = 8'd7;
          default: len = 8'd15;
        endcase
      end else begin
        len = 8'($urandom_range(0, 15));
      end
      addr = 32'($urandom_range(0, 'hBFF));
      if (bt == 2'd2) addr = addr & ~((32'd1 << size) - 32'd1);
`ifndef AXI_WR_ERR_CHK_EN
      if ($urandom_range(0, 3) == 0) addr = addr | 32'h0010_0000;
`endif
      for (int i = 0; i <= int'(len); i++) begin
        beat_data[i] = $urandom;
        beat_strb[i] = 4'($urandom_range(0, 15));
      end
      burst(4'($urandom_range(0, 15)), addr, len, size, bt, int'(len), -1, 2'd0,
            int'($urandom_range(0, 3)), -1, 1'b1);
    end
    for (int k = 0; k < 1024; k++) if (known[k] != 4'h0) check_word(k);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
